// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap controller: widths, CSR addresses,
// mstatus bit positions, FSM state encodings and mstatus update helpers.
// Optional feature macro: TRAP_VECTORED_EN (see trap_ctrl.sv).
package trap_ctrl_pkg;

  localparam int CSR_ADDR_WIDTH = 12;
  localparam int DATA_WIDTH     = 32;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVAL    = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    T_MEPC    = 4'd1,
    T_MCAUSE  = 4'd2,
    T_MTVAL   = 4'd3,
    T_MSTATUS = 4'd4,
    T_JUMP    = 4'd5,
    R_RD      = 4'd6,
    R_WR      = 4'd7,
    R_JUMP    = 4'd8
  } state_t;

  // Trap entry: stash MIE in MPIE, disable interrupts, previous mode = M.
  function automatic logic [DATA_WIDTH-1:0] trap_mstatus(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // MRET: restore MIE from MPIE, set MPIE, previous mode stays M.
  function automatic logic [DATA_WIDTH-1:0] mret_mstatus(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r = s;
    r[MSTATUS_MIE] = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer. In IDLE it passes the pipeline CSR read port and the
// WB write port straight through to the CSR file; while sequencing a trap or
// MRET it owns both ports, stalls the pipeline and finally redirects the PC.
// Optional feature macro: TRAP_VECTORED_EN enables vectored interrupt
// dispatch when mtvec mode bits are 01.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      exc_valid_i,
  input  logic [DATA_WIDTH-1:0]     exc_cause_i,
  input  logic [DATA_WIDTH-1:0]     exc_pc_i,
  input  logic [DATA_WIDTH-1:0]     exc_tval_i,
  input  logic                      mret_i,
  input  logic [CSR_ADDR_WIDTH-1:0] exe_raddr_i,
  output logic [DATA_WIDTH-1:0]     exe_rdata_o,
  input  logic                      wb_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [DATA_WIDTH-1:0]     wb_wdata_i,
  output logic                      wb_ready_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
  input  logic [DATA_WIDTH-1:0]     csr_rdata_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      busy_o,
  output logic                      redirect_valid_o,
  output logic [DATA_WIDTH-1:0]     redirect_pc_o
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, cause_q, tval_q, mstatus_q;
  logic [DATA_WIDTH-1:0] mtvec_base;
  logic [DATA_WIDTH-1:0] trap_target;

  // State register plus the trap context and mstatus snapshot latches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && exc_valid_i) begin
        pc_q    <= exc_pc_i;
        cause_q <= exc_cause_i;
        tval_q  <= exc_tval_i;
      end
      if (state_q == T_MTVAL || state_q == R_RD) begin
        mstatus_q <= csr_rdata_i;
      end
    end
  end

  // Next-state sequencing; a trap request beats a simultaneous MRET.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (exc_valid_i)  state_d = T_MEPC;
        else if (mret_i)  state_d = R_RD;
      end
      T_MEPC:    state_d = T_MCAUSE;
      T_MCAUSE:  state_d = T_MTVAL;
      T_MTVAL:   state_d = T_MSTATUS;
      T_MSTATUS: state_d = T_JUMP;
      T_JUMP:    state_d = IDLE;
      R_RD:      state_d = R_WR;
      R_WR:      state_d = R_JUMP;
      R_JUMP:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Trap target from mtvec as currently read back from the CSR file.
  always_comb begin
    mtvec_base  = {csr_rdata_i[DATA_WIDTH-1:2], 2'b00};
    trap_target = mtvec_base;
`ifdef TRAP_VECTORED_EN
    if (csr_rdata_i[1:0] == 2'b01 && cause_q[DATA_WIDTH-1]) begin
      trap_target = mtvec_base + {24'd0, cause_q[5:0], 2'b00};
    end
`endif
  end

  // Port ownership and per-state CSR accesses; reset forces the IDLE view.
  always_comb begin
    busy_o           = 1'b0;
    wb_ready_o       = 1'b0;
    exe_rdata_o      = '0;
    csr_raddr_o      = CSR_MSTATUS;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    if (rst_i || state_q == IDLE) begin
      wb_ready_o  = 1'b1;
      csr_raddr_o = exe_raddr_i;
      exe_rdata_o = csr_rdata_i;
      csr_we_o    = wb_we_i;
      csr_waddr_o = wb_waddr_i;
      csr_wdata_o = wb_wdata_i;
    end else begin
      busy_o = 1'b1;
      case (state_q)
        T_MEPC: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_MEPC;
          csr_wdata_o = pc_q & ~32'h3;
        end
        T_MCAUSE: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_MCAUSE;
          csr_wdata_o = cause_q;
        end
        T_MTVAL: begin
          csr_raddr_o = CSR_MSTATUS;
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_MTVAL;
          csr_wdata_o = tval_q;
        end
        T_MSTATUS: begin
          csr_raddr_o = CSR_MTVEC;
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_MSTATUS;
          csr_wdata_o = trap_mstatus(mstatus_q);
        end
        T_JUMP: begin
          csr_raddr_o      = CSR_MTVEC;
          redirect_valid_o = 1'b1;
          redirect_pc_o    = trap_target;
        end
        R_RD: begin
          csr_raddr_o = CSR_MSTATUS;
        end
        R_WR: begin
          csr_raddr_o = CSR_MEPC;
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_MSTATUS;
          csr_wdata_o = mret_mstatus(mstatus_q);
        end
        R_JUMP: begin
          csr_raddr_o      = CSR_MEPC;
          redirect_valid_o = 1'b1;
          redirect_pc_o    = csr_rdata_i;
        end
        default: begin
          busy_o = 1'b1;
        end
      endcase
    end
  end

endmodule
